// File: rtl/audio_codec_slave.sv
// Slave-mode left-justified audio serial port. The codec owns BCLK/LRCK; this block
// resynchronizes the pins, deserializes ADC words and serializes held DAC samples.
module audio_codec_slave #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_LRCK,
    input  logic                  AUD_ADCDAT,
    output logic                  AUD_DACDAT,
    output logic [DATA_WIDTH-1:0] adc_left,
    output logic [DATA_WIDTH-1:0] adc_right,
    output logic                  adc_valid,
    input  logic [DATA_WIDTH-1:0] dac_left,
    input  logic [DATA_WIDTH-1:0] dac_right,
    input  logic                  dac_load,
    output logic                  dac_req,
    output logic                  frame_err,
    output logic                  dac_underrun,
    input  logic                  status_clr
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int WW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ST_WARM,
        ST_ALIGN,
        ST_RUN
    } state_t;

    // Pin synchronizers: bit 0 BCLK, bit 1 LRCK, bit 2 ADCDAT.
    logic [2:0]            r_sync [SYNC_STAGES];
    logic                  r_bclk_prev;
    logic                  r_lrck_prev;
    logic [WW-1:0]         r_warm_cnt;
    state_t                r_state;
    state_t                w_state_next;
    logic                  w_ev_en;
    logic                  w_run;

    logic                  w_bclk;
    logic                  w_lrck;
    logic                  w_adc;
    logic                  w_lr_toggle;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_lr_edge;

    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift_in;
    logic [DATA_WIDTH-1:0] r_adc_left;
    logic [DATA_WIDTH-1:0] r_adc_right;
    logic                  r_adc_valid;
    logic                  r_frame_err;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_capture;
    logic                  w_last_bit;
    logic                  w_short_half;

    logic [DATA_WIDTH-1:0] r_hold_left;
    logic [DATA_WIDTH-1:0] r_hold_right;
    logic                  r_fresh;
    logic [DATA_WIDTH-1:0] r_shift_out;
    logic                  r_sampled;
    logic                  r_dac_req;
    logic                  r_dac_underrun;
    logic                  w_left_load;
    logic                  w_underrun_set;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so each stage samples the previous stage's old value.
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_bclk_prev <= 1'b0;
            r_lrck_prev <= 1'b0;
        end else begin
            r_sync[0] <= {AUD_ADCDAT, AUD_LRCK, AUD_BCLK};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_bclk_prev <= w_bclk;
            r_lrck_prev <= w_lrck;
        end
    end

    assign w_bclk      = r_sync[SYNC_STAGES-1][0];
    assign w_lrck      = r_sync[SYNC_STAGES-1][1];
    assign w_adc       = r_sync[SYNC_STAGES-1][2];
    assign w_lr_toggle = w_lrck ^ r_lrck_prev;

    // Events stay masked until the chains and prior flops hold real pin values,
    // so a pin sitting high at reset release is not mistaken for an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_warm_cnt <= '0;
        end else if (r_state == ST_WARM && r_warm_cnt != WW'(SYNC_STAGES)) begin
            r_warm_cnt <= r_warm_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_WARM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_ev_en      = 1'b0;
        w_run        = 1'b0;
        case (r_state)
            ST_WARM: begin
                if (r_warm_cnt == WW'(SYNC_STAGES)) begin
                    w_state_next = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                w_ev_en = 1'b1;
                if (w_lr_toggle) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_ev_en = 1'b1;
                w_run   = 1'b1;
            end
            default: w_state_next = ST_WARM;
        endcase
    end

    assign w_rise    = w_ev_en & w_bclk & ~r_bclk_prev;
    assign w_fall    = w_ev_en & ~w_bclk & r_bclk_prev;
    assign w_lr_edge = w_ev_en & w_lr_toggle;

    // ADC: bits are only captured once a genuine LRCK edge has framed the half.
    assign w_shift_next = {r_shift_in[DATA_WIDTH-2:0], w_adc};
    assign w_capture    = w_run & w_rise & ~w_lr_edge & (r_bit_cnt < CW'(DATA_WIDTH));
    assign w_last_bit   = w_capture & (r_bit_cnt == CW'(DATA_WIDTH - 1));
    assign w_short_half = w_run & w_lr_edge & (r_bit_cnt != CW'(DATA_WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            r_shift_in  <= '0;
            r_adc_left  <= '0;
            r_adc_right <= '0;
            r_adc_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_adc_valid <= 1'b0;
            r_frame_err <= w_short_half | (r_frame_err & ~status_clr);
            if (w_lr_edge) begin
                r_bit_cnt  <= '0;
                r_shift_in <= '0;
            end else if (w_capture) begin
                r_bit_cnt  <= r_bit_cnt + CW'(1);
                r_shift_in <= w_shift_next;
                if (w_last_bit) begin
                    if (w_lrck) begin
                        r_adc_left <= w_shift_next;
                    end else begin
                        r_adc_right <= w_shift_next;
                        r_adc_valid <= 1'b1;
                    end
                end
            end
        end
    end

    // DAC: a load coinciding with a left-frame load counts as a refresh; the old
    // value goes out now and the new pair waits for the next frame.
    assign w_left_load    = w_lr_edge & w_lrck;
    assign w_underrun_set = w_left_load & ~r_fresh & ~dac_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_left    <= '0;
            r_hold_right   <= '0;
            r_fresh        <= 1'b1;
            r_shift_out    <= '0;
            r_sampled      <= 1'b0;
            r_dac_req      <= 1'b0;
            r_dac_underrun <= 1'b0;
        end else begin
            r_dac_req      <= w_left_load;
            r_dac_underrun <= w_underrun_set | (r_dac_underrun & ~status_clr);
            if (dac_load) begin
                r_hold_left  <= dac_left;
                r_hold_right <= dac_right;
            end
            if (w_left_load) begin
                r_fresh <= dac_load;
            end else if (dac_load) begin
                r_fresh <= 1'b1;
            end
            // The sampled flag keeps a BCLK fall landing next to the LRCK edge from shifting twice.
            if (w_lr_edge) begin
                r_shift_out <= w_lrck ? r_hold_left : r_hold_right;
                r_sampled   <= 1'b0;
            end else if (w_fall && r_sampled) begin
                r_shift_out <= {r_shift_out[DATA_WIDTH-2:0], 1'b0};
                r_sampled   <= 1'b0;
            end else if (w_rise) begin
                r_sampled <= 1'b1;
            end
        end
    end

    assign AUD_DACDAT   = r_shift_out[DATA_WIDTH-1];
    assign adc_left     = r_adc_left;
    assign adc_right    = r_adc_right;
    assign adc_valid    = r_adc_valid;
    assign dac_req      = r_dac_req;
    assign frame_err    = r_frame_err;
    assign dac_underrun = r_dac_underrun;

endmodule
